// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: one FIFO per result source (ALU, LSU, FPU),
// round-robin selection and a single registered write port.
module writeback_arbiter #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [REG_W-1:0]  alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              alu_fp,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [REG_W-1:0]  lsu_rd,
   input  logic [DATA_W-1:0] lsu_data,
   input  logic              lsu_fp,
   input  logic              fpu_valid,
   output logic              fpu_ready,
   input  logic [REG_W-1:0]  fpu_rd,
   input  logic [DATA_W-1:0] fpu_data,
   input  logic              fpu_fp,
   output logic              RegWrite,
   output logic              FloatRegWrite,
   output logic [REG_W-1:0]  Write_reg,
   output logic [DATA_W-1:0] Write_data,
   output logic              idle
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      SRC_ALU = 2'd0,
      SRC_LSU = 2'd1,
      SRC_FPU = 2'd2
   } src_e;

   typedef struct packed {
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
      logic              fp;
   } entry_t;

   function automatic src_e nextSrc(input src_e s);
      case (s)
         SRC_ALU: return SRC_LSU;
         SRC_LSU: return SRC_FPU;
         default: return SRC_ALU;
      endcase
   endfunction

   entry_t            r_mem [3][DEPTH];
   logic [PW-1:0]     r_wrPtr [3];
   logic [PW-1:0]     r_rdPtr [3];
   logic [CW-1:0]     r_count [3];
   logic [2:0]        r_ready;
   src_e              r_ptr;
   logic              r_regWrite;
   logic              r_floatRegWrite;
   logic [REG_W-1:0]  r_writeReg;
   logic [DATA_W-1:0] r_writeData;

   logic [2:0]        w_inValid;
   entry_t            w_inEntry [3];
   logic [2:0]        w_push;
   logic [2:0]        w_pop;
   logic [CW-1:0]     w_countNext [3];
   logic              w_grantValid;
   src_e              w_grantIdx;
   entry_t            w_grantEntry;
   logic              w_allEmpty;

   always_comb begin
      w_inValid    = {fpu_valid, lsu_valid, alu_valid};
      w_inEntry[0] = '{rd: alu_rd, data: alu_data, fp: alu_fp};
      w_inEntry[1] = '{rd: lsu_rd, data: lsu_data, fp: lsu_fp};
      w_inEntry[2] = '{rd: fpu_rd, data: fpu_data, fp: fpu_fp};
   end

   // Search starts one past the last winner so every non-empty source waits at most 3 cycles.
   always_comb begin
      src_e probe;
      w_grantValid = 1'b0;
      w_grantIdx   = r_ptr;
      probe        = r_ptr;
      for (int k = 0; k < 3; k++) begin
         probe = nextSrc(probe);
         if (!w_grantValid && (r_count[probe] != '0)) begin
            w_grantValid = 1'b1;
            w_grantIdx   = probe;
         end
      end
   end

   always_comb begin
      w_pop = '0;
      if (w_grantValid) begin
         w_pop[w_grantIdx] = 1'b1;
      end
      w_grantEntry = r_mem[w_grantIdx][r_rdPtr[w_grantIdx]];
   end

   // Integer writes to x0 are handshaken but dropped; f0 is a real register.
   always_comb begin
      w_allEmpty = 1'b1;
      for (int i = 0; i < 3; i++) begin
         w_push[i]      = w_inValid[i] && r_ready[i] &&
                          (w_inEntry[i].fp || (w_inEntry[i].rd != '0));
         w_countNext[i] = r_count[i] + CW'(w_push[i]) - CW'(w_pop[i]);
         if (r_count[i] != '0) begin
            w_allEmpty = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            r_count[i] <= '0;
            r_wrPtr[i] <= '0;
            r_rdPtr[i] <= '0;
         end
         r_ready         <= '0;
         r_ptr           <= SRC_FPU;
         r_regWrite      <= 1'b0;
         r_floatRegWrite <= 1'b0;
         r_writeReg      <= '0;
         r_writeData     <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            r_count[i] <= w_countNext[i];
            r_ready[i] <= (w_countNext[i] != CW'(DEPTH));
            if (w_push[i]) begin
               r_wrPtr[i] <= r_wrPtr[i] + 1'b1;
            end
            if (w_pop[i]) begin
               r_rdPtr[i] <= r_rdPtr[i] + 1'b1;
            end
         end
         if (w_grantValid) begin
            r_ptr           <= w_grantIdx;
            r_regWrite      <= 1'b1;
            r_floatRegWrite <= w_grantEntry.fp;
            r_writeReg      <= w_grantEntry.rd;
            r_writeData     <= w_grantEntry.data;
         end else begin
            r_regWrite      <= 1'b0;
            r_floatRegWrite <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            if (w_push[i]) begin
               r_mem[i][r_wrPtr[i]] <= w_inEntry[i];
            end
         end
      end
   end

   assign alu_ready     = r_ready[0];
   assign lsu_ready     = r_ready[1];
   assign fpu_ready     = r_ready[2];
   assign RegWrite      = r_regWrite;
   assign FloatRegWrite = r_floatRegWrite;
   assign Write_reg     = r_writeReg;
   assign Write_data    = r_writeData;
   assign idle          = w_allEmpty && !r_regWrite;

endmodule
